// File: rtl/spi_apb_sequencer.sv
// APB master that configures the SPI core after reset and then runs one
// DR write / SR poll / DR read sequence per host byte request.
module spi_apb_sequencer #(
    parameter logic [7:0]  CR1_VAL    = 8'h50,
    parameter logic [7:0]  CR2_VAL    = 8'h00,
    parameter logic [7:0]  BR_VAL     = 8'h00,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req_valid,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    localparam int unsigned      CNT_W     = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST_POLL = CNT_W'(POLL_LIMIT - 1);

    localparam logic [2:0] ADDR_CR1 = 3'b000;
    localparam logic [2:0] ADDR_CR2 = 3'b001;
    localparam logic [2:0] ADDR_BR  = 3'b010;
    localparam logic [2:0] ADDR_SR  = 3'b011;
    localparam logic [2:0] ADDR_DR  = 3'b101;

    typedef enum logic [3:0] {
        CFG_CR1,
        CFG_CR2,
        CFG_BR,
        IDLE,
        DR_WR,
        SR_POLL,
        DR_RD,
        RESP,
        FAULT
    } state_t;

    state_t           state, state_next;
    logic             phase, phase_next;
    logic             running;
    logic [7:0]       tx_data, tx_next;
    logic [CNT_W-1:0] poll_cnt, poll_next;
    logic [7:0]       rsp_data_next;
    logic             rsp_err_next;
    logic             cfg_done_next;
    logic             cfg_err_next;

    logic             xfer;
    logic [2:0]       addr;
    logic             wr;
    logic [7:0]       wdata;
    logic             done;

    // running stays low for the cycle after reset so every output reads 0
    // while PRESET is held; the first CR1 SETUP follows the first free edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= CFG_CR1;
            phase    <= 1'b0;
            running  <= 1'b0;
            tx_data  <= '0;
            poll_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            running  <= 1'b1;
            tx_data  <= tx_next;
            poll_cnt <= poll_next;
            rsp_data <= rsp_data_next;
            rsp_err  <= rsp_err_next;
            cfg_done <= cfg_done_next;
            cfg_err  <= cfg_err_next;
        end
    end

    always_comb begin
        state_next    = state;
        phase_next    = phase;
        tx_next       = tx_data;
        poll_next     = poll_cnt;
        rsp_data_next = rsp_data;
        rsp_err_next  = rsp_err;
        cfg_done_next = cfg_done;
        cfg_err_next  = cfg_err;
        xfer          = 1'b0;
        addr          = '0;
        wr            = 1'b0;
        wdata         = '0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;

        case (state)
            CFG_CR1: begin
                xfer  = 1'b1;
                addr  = ADDR_CR1;
                wr    = 1'b1;
                wdata = CR1_VAL;
            end
            CFG_CR2: begin
                xfer  = 1'b1;
                addr  = ADDR_CR2;
                wr    = 1'b1;
                wdata = CR2_VAL;
            end
            CFG_BR: begin
                xfer  = 1'b1;
                addr  = ADDR_BR;
                wr    = 1'b1;
                wdata = BR_VAL;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tx_next    = req_data;
                    poll_next  = '0;
                    state_next = DR_WR;
                end
            end
            DR_WR: begin
                xfer  = 1'b1;
                addr  = ADDR_DR;
                wr    = 1'b1;
                wdata = tx_data;
            end
            SR_POLL: begin
                xfer = 1'b1;
                addr = ADDR_SR;
            end
            DR_RD: begin
                xfer = 1'b1;
                addr = ADDR_DR;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
            end
        endcase

        PSEL    = xfer && running;
        PENABLE = PSEL && phase;
        PADDR   = PSEL ? addr : '0;
        PWRITE  = PSEL && wr;
        PWDATA  = PSEL ? wdata : '0;
        done    = PENABLE && PREADY;

        if (PSEL && !phase) begin
            phase_next = 1'b1;
        end

        // Slave responses only matter on the completing ACCESS cycle.
        if (done) begin
            phase_next = 1'b0;
            case (state)
                CFG_CR1, CFG_CR2, CFG_BR: begin
                    if (PSLVERR) begin
                        state_next   = FAULT;
                        cfg_err_next = 1'b1;
                    end else if (state == CFG_CR1) begin
                        state_next = CFG_CR2;
                    end else if (state == CFG_CR2) begin
                        state_next = CFG_BR;
                    end else begin
                        state_next    = IDLE;
                        cfg_done_next = 1'b1;
                    end
                end
                DR_WR: begin
                    if (PSLVERR) begin
                        state_next    = RESP;
                        rsp_err_next  = 1'b1;
                        rsp_data_next = '0;
                    end else begin
                        state_next = SR_POLL;
                    end
                end
                SR_POLL: begin
                    if (PSLVERR || (!PRDATA[7] && poll_cnt == LAST_POLL)) begin
                        state_next    = RESP;
                        rsp_err_next  = 1'b1;
                        rsp_data_next = '0;
                    end else if (PRDATA[7]) begin
                        state_next = DR_RD;
                    end else begin
                        poll_next = poll_cnt + 1'b1;
                    end
                end
                DR_RD: begin
                    state_next    = RESP;
                    rsp_err_next  = PSLVERR;
                    rsp_data_next = PSLVERR ? 8'h00 : PRDATA;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
